fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_filter_param.sv | 130 +++++++++++++
 tb/tb_fir_filter_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// Sequential FIR filter: one multiply-accumulate per cycle over a TAPS-deep delay line,
// with coefficients writable at runtime. Define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_filter_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3,
  parameter int FRAC   = 4,
  parameter int OUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      coef_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data
);

  localparam int KW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + KW;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic [KW:0]   TAPS_L = (KW + 1)'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state_q;
  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [KW-1:0]            k_q;
  logic                     out_valid_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     coef_err_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  out_data_d;
  logic                     addr_bad;
  logic                     coef_ok;

`ifdef FIR_SAT_EN
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [EXT_W-1:0] ext;
`endif

  // The final product is folded in combinationally so the result is ready on entry to OUT.
  always_comb begin
    prod     = PROD_W'(coef_q[k_q]) * PROD_W'(x_q[k_q]);
    acc_d    = acc_q + ACC_W'(prod);
    shifted  = acc_d >>> FRAC;
`ifdef FIR_SAT_EN
    ext = EXT_W'(shifted);
    if (ext > SAT_MAX) begin
      out_data_d = SAT_MAX[OUT_W-1:0];
    end else if (ext < SAT_MIN) begin
      out_data_d = SAT_MIN[OUT_W-1:0];
    end else begin
      out_data_d = ext[OUT_W-1:0];
    end
`else
    out_data_d = OUT_W'(shifted);
`endif
    addr_bad = ({1'b0, coef_addr} >= TAPS_L);
    coef_ok  = coef_we && (state_q == IDLE) && !addr_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      coef_err_q <= coef_we && !coef_ok;
      if (coef_ok) begin
        coef_q[coef_addr] <= coef_data;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
              x_q[i] <= x_q[i-1];
            end
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param: a default-parameter instance plus an
// 8-bit-output, FRAC=0 instance for the overflow case (expectation follows FIR_SAT_EN).
module tb_fir_filter_param;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic              m_coef_we, m_coef_err, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [1:0]        m_coef_addr;
  logic signed [7:0] m_coef_data, m_in_data;
  logic signed [15:0] m_out_data;

  logic              o_coef_we, o_coef_err, o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [1:0]        o_coef_addr;
  logic signed [7:0] o_coef_data, o_in_data;
  logic signed [7:0] o_out_data;

  int  mExpQ[$], mLatQ[$], oExpQ[$], oLatQ[$];
  bit  mSeen, oSeen;
  int  mRiseCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fir_filter_param dutMain (
    .clk(clk), .rst(rst),
    .coef_we(m_coef_we), .coef_addr(m_coef_addr), .coef_data(m_coef_data), .coef_err(m_coef_err),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data)
  );

  fir_filter_param #(.OUT_W(8), .FRAC(0)) dutOvf (
    .clk(clk), .rst(rst),
    .coef_we(o_coef_we), .coef_addr(o_coef_addr), .coef_data(o_coef_data), .coef_err(o_coef_err),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitReady(input int sel);
    int guard = 0;
    while (!(sel == 0 ? m_in_ready : o_in_ready) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL in_ready_wait: got 0, expected 1");
    end
  endtask

  task automatic applyStimulus(input int sel, input int sample, input int expected, input bit push);
    @(posedge clk); #1;
    waitReady(sel);
    if (sel == 0) begin
      m_in_valid = 1'b1;
      m_in_data  = 8'(sample);
    end else begin
      o_in_valid = 1'b1;
      o_in_data  = 8'(sample);
    end
    if (push && sel == 0) begin
      mExpQ.push_back(expected);
      mLatQ.push_back(cycle);
    end else if (push) begin
      oExpQ.push_back(expected);
      oLatQ.push_back(cycle);
    end
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    o_in_valid = 1'b0;
  endtask

  task automatic writeCoef(input int sel, input logic [1:0] addr, input int value);
    @(posedge clk); #1;
    if (sel == 0) begin
      m_coef_we = 1'b1; m_coef_addr = addr; m_coef_data = 8'(value);
    end else begin
      o_coef_we = 1'b1; o_coef_addr = addr; o_coef_data = 8'(value);
    end
    @(posedge clk); #1;
    m_coef_we = 1'b0;
    o_coef_we = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((mExpQ.size() != 0 || oExpQ.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending, expected 0", mExpQ.size(), oExpQ.size());
    end
    @(posedge clk); #1;
  endtask

  // Main-instance monitor: latency is checked at the rise of out_valid, data at the handshake.
  always @(negedge clk) begin
    if (rst) begin
      mSeen = 1'b0;
    end else if (m_out_valid) begin
      if (!mSeen) begin
        mSeen = 1'b1;
        mRiseCount++;
        if (mLatQ.size() == 0) checkOutput("main_unexpected_valid", 1, 0);
        else checkOutput("main_latency", cycle - mLatQ[0], LAT);
      end
      if (m_out_ready) begin
        if (mExpQ.size() != 0) begin
          checkOutput("main_out_data", m_out_data, mExpQ.pop_front());
          void'(mLatQ.pop_front());
        end
        mSeen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      oSeen = 1'b0;
    end else if (o_out_valid) begin
      if (!oSeen) begin
        oSeen = 1'b1;
        if (oLatQ.size() == 0) checkOutput("ovf_unexpected_valid", 1, 0);
        else checkOutput("ovf_latency", cycle - oLatQ[0], LAT);
      end
      if (o_out_ready) begin
        if (oExpQ.size() != 0) begin
          checkOutput("ovf_out_data", o_out_data, oExpQ.pop_front());
          void'(oLatQ.pop_front());
        end
        oSeen = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int riseBefore;
    rst = 1'b1;
    m_coef_we = 0; m_coef_addr = 0; m_coef_data = 0; m_in_valid = 0; m_in_data = 0; m_out_ready = 1;
    o_coef_we = 0; o_coef_addr = 0; o_coef_data = 0; o_in_valid = 0; o_in_data = 0; o_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", m_out_valid, 0);
    checkOutput("rst_out_data", m_out_data, 0);
    checkOutput("rst_coef_err", m_coef_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", m_in_ready, 1);

    $display("[TB] zero coefficients give zero output");
    applyStimulus(0, 50, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    drain();

    $display("[TB] impulse with coefficients 8,5,10");
    writeCoef(0, 2'd0, 8);
    writeCoef(0, 2'd1, 5);
    writeCoef(0, 2'd2, 10);
    checkOutput("legal_write_no_err", m_coef_err, 0);
    applyStimulus(0, 16, 8, 1);
    applyStimulus(0, 0, 5, 1);
    applyStimulus(0, 0, 10, 1);

    $display("[TB] mixed-sign samples");
    applyStimulus(0, 32, 16, 1);
    applyStimulus(0, -16, 2, 1);
    applyStimulus(0, 7, 18, 1);
    drain();

    $display("[TB] coefficient write alongside sample, negative truncation");
    writeCoef(0, 2'd1, 0);
    writeCoef(0, 2'd2, 0);
    @(posedge clk); #1;
    waitReady(0);
    m_in_valid = 1'b1; m_in_data = -8'sd20;
    m_coef_we = 1'b1; m_coef_addr = 2'd0; m_coef_data = 8'sd1;
    mExpQ.push_back(-2);
    mLatQ.push_back(cycle);
    @(posedge clk); #1;
    m_in_valid = 1'b0; m_coef_we = 1'b0;
    applyStimulus(0, -1, -1, 1);
    drain();

    $display("[TB] back-pressure");
    m_out_ready = 1'b0;
    applyStimulus(0, 64, 4, 1);
    guard = 0;
    while (!m_out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("bp_valid_timeout", 0, 1);
    m_in_valid = 1'b1; m_in_data = 8'sd48;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", m_out_valid, 1);
      checkOutput("bp_out_data", m_out_data, 4);
      checkOutput("bp_in_ready", m_in_ready, 0);
    end
    m_out_ready = 1'b1;
    mExpQ.push_back(3);
    mLatQ.push_back(cycle + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;

    $display("[TB] coefficient lockout");
    applyStimulus(0, 80, 5, 1);
    m_coef_we = 1'b1; m_coef_addr = 2'd0; m_coef_data = 8'sd50;
    @(posedge clk); #1;
    m_coef_we = 1'b0;
    checkOutput("mac_write_err_pulse", m_coef_err, 1);
    @(posedge clk); #1;
    checkOutput("mac_write_err_clear", m_coef_err, 0);
    applyStimulus(0, 32, 2, 1);
    drain();
    writeCoef(0, 2'd3, 99);
    checkOutput("bad_addr_err_pulse", m_coef_err, 1);
    @(posedge clk); #1;
    checkOutput("bad_addr_err_clear", m_coef_err, 0);
    applyStimulus(0, 16, 1, 1);
    drain();

    $display("[TB] reset during MAC");
    riseBefore = mRiseCount;
    applyStimulus(0, 16, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_in_ready", m_in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_valid", mRiseCount - riseBefore, 0);
    applyStimulus(0, 16, 0, 1);
    drain();

    $display("[TB] overflow instance");
    for (int i = 0; i < 3; i++) writeCoef(1, 2'(i), 127);
`ifdef FIR_SAT_EN
    applyStimulus(1, 127, 127, 1);
    applyStimulus(1, 127, 127, 1);
    applyStimulus(1, 127, 127, 1);
`else
    applyStimulus(1, 127, 1, 1);
    applyStimulus(1, 127, 2, 1);
    applyStimulus(1, 127, 3, 1);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
